// File: rtl/img_cap_pkg.sv
// Shared types and constants for the image capture write path.
// Pixels are RGB888, frame-buffer words are 32 bits with a zero pad on top.
package img_cap_pkg;

    localparam int PIX_W  = 24;
    localparam int WORD_W = 32;

    localparam logic [WORD_W-PIX_W-1:0] PIX_PAD = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } wr_ctrl_state_t;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous pixel FIFO with flush. Push while full is legal only together
// with a pop; flush discards contents and may be combined with a push.
module pix_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_addr;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A flush rewinds both pointers; a pixel pushed in the same cycle lands in slot 0.
    assign wr_addr = flush ? '0 : wr_ptr_q[AW-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = push ? (AW+1)'(1) : '0;
            rd_ptr_d = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_addr] <= push_data;
    end

endmodule

// File: rtl/img_wr_ctrl.sv
// Frame-buffer write-side capture controller: buffers a 24-bit pixel stream,
// tracks frame geometry, reports done/abort/overflow. IMG_WR_CTRL_STATS_EN adds drop_cnt.
module img_wr_ctrl
    import img_cap_pkg::*;
#(
    parameter int FRAME_PIXELS = 307200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_en,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_sof,
    input  logic              wr_rdy,
    output logic              wr_en_in,
    output logic [WORD_W-1:0] wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic              overflow,
    output logic              busy
`ifdef IMG_WR_CTRL_STATS_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS);

    wr_ctrl_state_t   state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             overflow_q, overflow_d;
    logic             frame_err_q, frame_err_d;

    logic             fifo_push, fifo_pop, fifo_flush;
    logic             fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [PIX_W-1:0] fifo_head;
    logic             start, restart, drop, last_pop;

    pix_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (pix_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .head      (fifo_head)
    );

    assign fifo_pop   = (state_q == ST_CAPTURE || state_q == ST_DRAIN) && !fifo_empty && wr_rdy;
    assign wr_en_in   = fifo_pop;
    assign wr_data    = fifo_empty ? '0 : {PIX_PAD, fifo_head};
    assign frame_done = (state_q == ST_DONE);
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != ST_IDLE);

    // The final write empties the FIFO, so DONE follows it with no idle cycle.
    assign last_pop = fifo_empty || (fifo_level == LVL_W'(1) && fifo_pop);

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        overflow_d  = overflow_q;
        frame_err_d = 1'b0;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        start       = 1'b0;
        restart     = 1'b0;
        drop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pix_valid && pix_sof && cap_en) begin
                    start     = 1'b1;
                    fifo_push = 1'b1;
                    in_cnt_d  = CNT_W'(1);
                    state_d   = (in_cnt_d == LAST_PIX) ? ST_DRAIN : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (pix_valid) begin
                    if (pix_sof) begin
                        restart     = 1'b1;
                        fifo_flush  = 1'b1;
                        fifo_push   = 1'b1;
                        frame_err_d = 1'b1;
                        in_cnt_d    = CNT_W'(1);
                    end else begin
                        // A dropped pixel still counts so the frame ends on geometry.
                        in_cnt_d = in_cnt_q + CNT_W'(1);
                        if (fifo_full && !fifo_pop)
                            drop = 1'b1;
                        else
                            fifo_push = 1'b1;
                    end
                    if (in_cnt_d == LAST_PIX)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (in_cnt_q == LAST_PIX && last_pop)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (drop)
            overflow_d = 1'b1;

        if (start || restart)
            out_cnt_d = '0;
        else if (fifo_pop)
            out_cnt_d = out_cnt_q + CNT_W'(1);
        else
            out_cnt_d = out_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef IMG_WR_CTRL_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only a fresh start clears the count; an aborted frame keeps accumulating.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (start)
            drop_cnt_d = '0;
        else if (drop)
            drop_cnt_d = sat_inc16(drop_cnt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt_q <= '0;
        else
            drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/img_wr_ctrl.md
# img_wr_ctrl

Write-side capture controller that sits directly upstream of the frame buffer. It accepts a 24-bit pixel stream with start-of-frame marking and buffers pixels in a small FIFO. It presents each pixel to the frame buffer's write port as a zero-extended 32-bit word, gated by the buffer's write-ready. It tracks frame boundaries, signals frame completion, and flags overflow and short-frame errors.

## Interface
- `FRAME_PIXELS`, default 307200: pixels per frame (640x480).
- `FIFO_DEPTH`, default 16: pixel FIFO entries; power of two, at least 2.
- `clk` in 1: single clock, 125 MHz domain shared with the frame buffer.
- `reset` in 1: asynchronous, active-high.
- `cap_en` in 1: arms capture; sampled only in IDLE.
- `pix_valid` in 1: pixel strobe.
- `pix_data` in 24: RGB888 pixel.
- `pix_sof` in 1: qualifies the first pixel of a frame; meaningful only with `pix_valid`.
- `wr_rdy` in 1: frame buffer can accept a write this cycle.
- `wr_en_in` out 1: write strobe to the frame buffer.
- `wr_data` out 32: `{8'h00, pixel}`.
- `frame_done` out 1: one-cycle pulse when the last pixel of a frame is written.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.
- `overflow` out 1: sticky; a pixel was dropped because the FIFO was full. Cleared only by reset.
- `busy` out 1: state is not IDLE.

## Operation
- **States:** IDLE, CAPTURE, DRAIN, DONE.
- **IDLE:**
  - Pixels without `pix_sof` are discarded silently.
  - `pix_valid & pix_sof & cap_en` pushes that pixel, sets `in_cnt = 1`, and moves to CAPTURE.
- **CAPTURE:**
  - Every `pix_valid` pushes a pixel if the FIFO is not full; `in_cnt` increments on each push.
  - When the FIFO is full, the pixel is dropped, `overflow` is set, and `in_cnt` still increments. This keeps frame geometry intact.
  - When `in_cnt` reaches `FRAME_PIXELS`, move to DRAIN. If that same cycle's pixel is the last one, the transition occurs after the push.
- **`pix_sof` during CAPTURE:**
  - Flush the FIFO.
  - Pulse `frame_err`.
  - Reset `in_cnt` and `out_cnt`, then restart the frame with this pixel (`in_cnt = 1`).
- **DRAIN:** input pixels are ignored. `pix_sof` here is ignored, not an error.
- **Write side (CAPTURE and DRAIN):**
  - `wr_en_in = !fifo_empty & wr_rdy`.
  - `wr_data` is the FIFO head.
  - A write and pop occur in every cycle `wr_en_in` is 1. `out_cnt` increments on each.
- **Drain completion:**
  - `out_cnt` counts written pixels.
  - DRAIN ends when `out_cnt + dropped == FRAME_PIXELS`, equivalently when the FIFO is empty and `in_cnt == FRAME_PIXELS`. Then move to DONE.
- **DONE:** pulse `frame_done` for one cycle, then return to IDLE.
- **Simultaneous push and pop:** allowed on a full FIFO when `wr_en_in` is 1, so no drop occurs.
- **Counters:** `in_cnt` and `out_cnt` are `$clog2(FRAME_PIXELS+1)` bits wide; no wrap within a frame.

## Timing
- **Reset values:**
  - `wr_en_in = 0`, `wr_data = 0`, `frame_done = 0`, `frame_err = 0`, `overflow = 0`, `busy = 0`.
  - State IDLE, FIFO empty, counters 0.
- **Latency:** a pixel accepted at edge N is at the FIFO head after edge N. `wr_en_in` can assert in cycle N+1 at the earliest.
- `wr_en_in` is combinational from registered FIFO state and `wr_rdy`. If `wr_rdy` is low, the head is held.
- `frame_done` asserts in the cycle after the final write.
- `frame_err` asserts in the cycle after the offending `pix_sof`.
- **Asynchronous reset mid-frame:** all state is cleared immediately and FIFO contents are discarded. No `frame_done` or `frame_err` is issued.
- **Throughput:** 1 pixel/cycle sustained while `wr_rdy` stays high.

## Configuration
- `IMG_WR_CTRL_STATS_EN` defined:
  - Adds output `drop_cnt` (16 bits): count of dropped pixels.
  - Saturates at 16'hFFFF.
  - Cleared by reset and on each new-frame start in IDLE.
  - Not cleared on abort; the restarted frame keeps accumulating.
- Not defined: the port is absent and only the sticky `overflow` is provided.

## Structure
- Shared package `img_cap_pkg`:
  - `PIX_W = 24`, `WORD_W = 32`.
  - State enum `wr_ctrl_state_t`.
  - Pad constant `PIX_PAD = 8'h00`.
- One sub-module, `pix_fifo`:
  - Synchronous FIFO parameterised on width and depth.
  - Ports: push, pop, flush, `full`, `empty`, head data.
  - Same `clk`/`reset`.

## Test plan
All scenarios use `FRAME_PIXELS = 8` and `FIFO_DEPTH = 4`.
- **Clean frame:** `cap_en = 1`, 8 pixels 24'h000001..24'h000008, first with `pix_sof`, `wr_rdy` held high → 8 writes of 32'h00000001..32'h00000008 in order; one `frame_done` pulse; `overflow = 0`.
- **Backpressure:** `wr_rdy` low for 3 cycles during a frame at 1 pixel/cycle → no drops while FIFO occupancy ≤ 4; writes resume in order; `frame_done` after the 8th write.
- **Overflow:** `wr_rdy` held low for the whole input burst of 8 pixels → first 4 stored, last 4 dropped; `overflow` sticky 1; 4 writes once `wr_rdy` rises; `frame_done`; `drop_cnt = 4` when `IMG_WR_CTRL_STATS_EN` is defined.
- **Abort:** `pix_sof` on the 5th pixel of a frame → `frame_err` pulse; FIFO flushed; the next 8 pixels starting from that one complete the frame with `frame_done`.
- **IDLE filtering:** pixels without `pix_sof`, or with `cap_en = 0` → no writes and `busy` stays 0.
- **Async reset mid-DRAIN:** assert `reset` with 3 pixels still queued → `wr_en_in` drops immediately; state IDLE; no `frame_done`.
